// File: rtl/data_stack_if.sv
// Operand/result bundle between the Forth data stack and its controller/ALU.
interface data_stack_if #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
);
    localparam int unsigned DepthW = $clog2(Depth + 1);

    logic [2:0]        stack_op;
    logic [Width-1:0]  din;
    logic [Width-1:0]  alu_res;
    logic [Width-1:0]  tos;
    logic [Width-1:0]  nos;
    logic [DepthW-1:0] depth;
    logic              empty;
    logic              full;
    logic              err;

    modport master (
        output stack_op, din, alu_res,
        input  tos, nos, depth, empty, full, err
    );

    modport slave (
        input  stack_op, din, alu_res,
        output tos, nos, depth, empty, full, err
    );
endinterface

// File: rtl/data_stack.sv
// Forth data stack: TOS/NOS in registers feeding the ALU, deeper items spilled to an array.
module data_stack #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic       clk,
    input  logic       rst,
    data_stack_if.slave bus
);
    localparam int unsigned DepthW   = $clog2(Depth + 1);
    localparam int unsigned MemDepth = Depth - 2;
    localparam int unsigned SpW      = $clog2(Depth - 1);

    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);
    localparam logic [DepthW-1:0] One      = DepthW'(1);
    localparam logic [DepthW-1:0] Two      = DepthW'(2);
    localparam logic [DepthW-1:0] Three    = DepthW'(3);

    typedef enum logic [2:0] {
        OpNop, OpPush, OpPop, OpBinary, OpUnary, OpDup, OpSwap, OpOver
    } op_e;

    logic [Width-1:0]  tos_q, tos_d;
    logic [Width-1:0]  nos_q, nos_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic [SpW-1:0]    sp_q, sp_d;
    logic              err_q, err_d;

    logic [Width-1:0]  mem_q [MemDepth];
    logic              mem_we;
    logic [SpW-1:0]    rd_idx;
    logic              push_en;
    logic              pull_en;
    logic [Width-1:0]  push_val;

    assign rd_idx = sp_q - SpW'(1);

    always_comb begin
        tos_d    = tos_q;
        nos_d    = nos_q;
        depth_d  = depth_q;
        sp_d     = sp_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        push_en  = 1'b0;
        pull_en  = 1'b0;
        push_val = bus.din;

        unique case (op_e'(bus.stack_op))
            OpNop: ;
            OpPush: begin
                if (depth_q < DepthMax) push_en = 1'b1;
                else                    err_d   = 1'b1;
            end
            OpPop: begin
                if (depth_q >= One) begin
                    tos_d   = nos_q;
                    pull_en = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            OpBinary: begin
                if (depth_q >= Two) begin
                    tos_d   = bus.alu_res;
                    pull_en = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            OpUnary: begin
                if (depth_q >= One) tos_d = bus.alu_res;
                else                err_d = 1'b1;
            end
            OpDup: begin
                push_val = tos_q;
                if (depth_q >= One && depth_q < DepthMax) push_en = 1'b1;
                else                                      err_d   = 1'b1;
            end
            OpSwap: begin
                if (depth_q >= Two) begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            OpOver: begin
                push_val = nos_q;
                if (depth_q >= Two && depth_q < DepthMax) push_en = 1'b1;
                else                                      err_d   = 1'b1;
            end
            default: ;
        endcase

        if (push_en) begin
            nos_d   = tos_q;
            tos_d   = push_val;
            depth_d = depth_q + One;
            if (depth_q >= Two) begin
                mem_we = 1'b1;
                sp_d   = sp_q + SpW'(1);
            end
        end

        // Refill NOS from the array top in the same edge; zero it once nothing lies beneath.
        if (pull_en) begin
            depth_d = depth_q - One;
            if (depth_q >= Three) begin
                nos_d = mem_q[rd_idx];
                sp_d  = rd_idx;
            end else begin
                nos_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Spill array is never observable before being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[sp_q] <= nos_q;
    end

    assign bus.tos   = tos_q;
    assign bus.nos   = nos_q;
    assign bus.depth = depth_q;
    assign bus.err   = err_q;
    assign bus.empty = (depth_q == '0);
    assign bus.full  = (depth_q == DepthMax);
endmodule
